// File: rtl/rr_arbiter_8x1_32bit_if.sv
// ---------------------------------------------------------------------------
// rr_arbiter_8x1_32bit_if
//   Bundles the eight requester ports and the single downstream port of the
//   round-robin arbiter.
//
//   Signals:
//     req_valid   [7:0]        bit i: requester i offers req_data_i
//     req_data_0..req_data_7   requester words (DATA_W each)
//     req_ready   [7:0]        one-hot or zero: requester i accepted this cycle
//     out_valid                output register holds a word
//     out_data    [DATA_W-1:0] registered word
//     out_src     [2:0]        index of the requester that supplied out_data
//     out_ready                consumer accepts out_data when out_valid is high
//
//   Modports:
//     master : the producer/consumer side (drives requests and out_ready)
//     slave  : the arbiter side
// ---------------------------------------------------------------------------
interface rr_arbiter_8x1_32bit_if #(
  parameter int unsigned DATA_W = 32
);

  logic [7:0]        req_valid;
  logic [DATA_W-1:0] req_data_0;
  logic [DATA_W-1:0] req_data_1;
  logic [DATA_W-1:0] req_data_2;
  logic [DATA_W-1:0] req_data_3;
  logic [DATA_W-1:0] req_data_4;
  logic [DATA_W-1:0] req_data_5;
  logic [DATA_W-1:0] req_data_6;
  logic [DATA_W-1:0] req_data_7;
  logic [7:0]        req_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_src;
  logic              out_ready;

  modport master (
    output req_valid,
    output req_data_0, req_data_1, req_data_2, req_data_3,
    output req_data_4, req_data_5, req_data_6, req_data_7,
    input  req_ready,
    input  out_valid,
    input  out_data,
    input  out_src,
    output out_ready
  );

  modport slave (
    input  req_valid,
    input  req_data_0, req_data_1, req_data_2, req_data_3,
    input  req_data_4, req_data_5, req_data_6, req_data_7,
    output req_ready,
    output out_valid,
    output out_data,
    output out_src,
    input  out_ready
  );

endinterface

// File: rtl/rr_arbiter_8x1_32bit.sv
// ---------------------------------------------------------------------------
// rr_arbiter_8x1_32bit
//   Round-robin arbiter sharing one DATA_W-bit downstream port among eight
//   requesters. The winner's word is captured into a one-entry output
//   register with a valid/ready handshake. A drain and a new load may happen
//   in the same cycle, so the block sustains one word per cycle.
//
//   Ports:
//     clk    : clock, all state updates on the rising edge
//     reset  : synchronous, active-high; clears the output register and
//              points the priority at requester 0
//     bus    : rr_arbiter_8x1_32bit_if.slave (requests, grants, output port)
// ---------------------------------------------------------------------------
module rr_arbiter_8x1_32bit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  rr_arbiter_8x1_32bit_if.slave  bus
);

  localparam int unsigned N_REQ = 8;

  // State
  logic [2:0]        r_last_grant;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [2:0]        r_out_src;

  // Combinational
  logic              w_drain;
  logic              w_can_load;
  logic              w_any_req;
  logic              w_load;
  logic              w_found;
  logic [2:0]        w_winner;
  logic [DATA_W-1:0] w_win_data;
  logic [7:0]        w_req_ready;

  assign w_drain    = r_out_valid & bus.out_ready;
  assign w_can_load = ~r_out_valid | w_drain;
  assign w_any_req  = |bus.req_valid;
  assign w_load     = w_can_load & w_any_req & ~reset;

  // Search starts just after the last winner and wraps through it; the
  // 3-bit add provides the mod-8 wrap for free.
  always_comb begin
    logic [2:0] idx;
    w_winner = r_last_grant;
    w_found  = 1'b0;
    idx      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = r_last_grant + 3'(k);
      if (!w_found && bus.req_valid[idx]) begin
        w_winner = idx;
        w_found  = 1'b1;
      end
    end
  end

  // Data steering only feeds the register; grants never see req_data.
  always_comb begin
    w_win_data = '0;
    case (w_winner)
      3'd0:    w_win_data = bus.req_data_0;
      3'd1:    w_win_data = bus.req_data_1;
      3'd2:    w_win_data = bus.req_data_2;
      3'd3:    w_win_data = bus.req_data_3;
      3'd4:    w_win_data = bus.req_data_4;
      3'd5:    w_win_data = bus.req_data_5;
      3'd6:    w_win_data = bus.req_data_6;
      default: w_win_data = bus.req_data_7;
    endcase
  end

  always_comb begin
    w_req_ready = '0;
    if (w_load) begin
      w_req_ready = 8'b1 << w_winner;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_src    <= '0;
      r_last_grant <= 3'd7;
    end else if (w_can_load) begin
      if (w_any_req) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= w_win_data;
        r_out_src    <= w_winner;
        r_last_grant <= w_winner;
      end else begin
        // Data and source are left as-is; consumer ignores them when invalid.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_src   = r_out_src;

endmodule

// File: tb/tb_rr_arbiter_8x1_32bit.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_8x1_32bit
//   Self-checking bench: directed scenarios followed by randomized traffic,
//   all compared against a behavioural model of the arbiter.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_8x1_32bit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rr_arbiter_8x1_32bit_if #(.DATA_W(32)) bus ();

  logic [31:0] d [8];
  assign bus.req_data_0 = d[0];
  assign bus.req_data_1 = d[1];
  assign bus.req_data_2 = d[2];
  assign bus.req_data_3 = d[3];
  assign bus.req_data_4 = d[4];
  assign bus.req_data_5 = d[5];
  assign bus.req_data_6 = d[6];
  assign bus.req_data_7 = d[7];

  rr_arbiter_8x1_32bit #(.DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural model state
  bit          m_valid;
  logic [31:0] m_data;
  int          m_src;
  int          m_last;
  int          grant_cnt [8];
  logic [7:0]  last_rdy;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Round-robin rule: first valid requester after the last winner, wrapping.
  function automatic int pick(input int last, input logic [7:0] v);
    for (int k = 1; k <= 8; k++) begin
      int idx;
      idx = (last + k) % 8;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 32'h0;
    m_src   = 0;
    m_last  = 7;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    int         w;
    bit         can;
    logic [7:0] exp_rdy;
    @(negedge clk);
    can = !m_valid || (bus.out_ready === 1'b1);
    w   = pick(m_last, bus.req_valid);
    exp_rdy = (!reset && can && w >= 0) ? 8'(1 << w) : 8'h00;
    check_eq("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    check_eq("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check_eq("out_data",  bus.out_data, m_data);
    check_eq("out_src",   32'(bus.out_src), 32'(m_src));
    last_rdy = bus.req_ready;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else if (can) begin
      if (w >= 0) begin
        m_valid = 1'b1;
        m_data  = d[w];
        m_src   = w;
        m_last  = w;
        grant_cnt[w]++;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = 8'hFF;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) d[i] = 32'h0;
    @(posedge clk);
    #1;
    model_reset();

    // Reset held two cycles with all requesters valid
    step();
    step();
    reset = 1'b0;
    step();
    check_eq("rst_release_rdy", 32'(last_rdy), 32'h01);

    // Single requester
    do_reset();
    bus.req_valid = 8'h08;
    d[3] = 32'hDEADBEEF;
    step();
    check_eq("single_rdy", 32'(last_rdy), 32'h08);
    bus.req_valid = 8'h00;
    check_eq("single_data", bus.out_data, 32'hDEADBEEF);
    check_eq("single_src",  32'(bus.out_src), 32'd3);
    step();

    // Full rotation and fairness
    do_reset();
    for (int i = 0; i < 8; i++) begin
      d[i] = 32'h1000_0000 + 32'(i);
      grant_cnt[i] = 0;
    end
    bus.req_valid = 8'hFF;
    for (int k = 0; k < 16; k++) begin
      step();
      check_eq("rot_src",  32'(bus.out_src), 32'(k % 8));
      check_eq("rot_data", bus.out_data, 32'h1000_0000 + 32'(k % 8));
    end
    for (int i = 0; i < 8; i++) check_eq("fair_cnt", 32'(grant_cnt[i]), 32'd2);

    // Backpressure
    do_reset();
    bus.req_valid = 8'hFF;
    step(); step(); step();
    check_eq("bp_pre_src", 32'(bus.out_src), 32'd2);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("bp_rdy",  32'(last_rdy), 32'h00);
      check_eq("bp_src",  32'(bus.out_src), 32'd2);
      check_eq("bp_data", bus.out_data, 32'h1000_0002);
    end
    bus.out_ready = 1'b1;
    step();
    check_eq("bp_release_rdy", 32'(last_rdy), 32'h08);
    check_eq("bp_release_src", 32'(bus.out_src), 32'd3);

    // Wrap and skip: last grant 6, then only 0 and 6 requesting
    do_reset();
    bus.req_valid = 8'h40;
    step();
    bus.req_valid = 8'h41;
    step();
    check_eq("wrap_g0", 32'(last_rdy), 32'h01);
    step();
    check_eq("wrap_g1", 32'(last_rdy), 32'h40);
    step();
    check_eq("wrap_g2", 32'(last_rdy), 32'h01);

    // Reset mid-operation with a word stuck in the output register
    bus.out_ready = 1'b0;
    bus.req_valid = 8'h80;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    check_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mid_rst_data",  bus.out_data, 32'h0);
    check_eq("mid_rst_src",   32'(bus.out_src), 32'd0);
    step();
    check_eq("mid_rst_rdy", 32'(last_rdy), 32'h80);
    check_eq("mid_rst_src7", 32'(bus.out_src), 32'd7);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      reset         = ($urandom_range(0, 199) == 0);
      bus.req_valid = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 8; i++) d[i] = $urandom;
      step();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8x1_32bit.md
# rr_arbiter_8X1_32bit

Round-robin arbiter and output stage that shares one 32-bit downstream port among eight requesters. Each cycle it picks at most one valid requester and steers that requester's word through an 8:1 32-bit select. It captures the word into a one-entry output register with a valid/ready handshake. It sits between multiple producers (e.g. forwarding or writeback sources) and a single consumer in the pipeline datapath.

## Interface
- DATA_W, 32, data width of every requester word and of the output; the requester count is fixed at 8.

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  8  bit i high means requester i offers req_data_i.
- req_data_0 … req_data_7  input  DATA_W each  requester words.
- req_ready  output  8  one-hot or zero; bit i high means requester i's word is accepted this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  DATA_W  registered word.
- out_src  output  3  index of the requester that supplied out_data.
- out_ready  input  1  consumer accepts out_data this cycle when out_valid is also high.

## Operation
- State:
  - Output register: out_valid, out_data, out_src.
  - Priority pointer last_grant (3 bits).
- Definitions:
  - drain = out_valid & out_ready.
  - can_load = !out_valid | drain.
- Winner selection:
  - Search req_valid starting at index (last_grant + 1) mod 8 and wrap through index last_grant inclusive.
  - The winner is the first asserted bit found.
  - The search is purely combinational.
- Per cycle, when reset is low:
  - If can_load and req_valid != 0:
    - req_ready = one-hot(winner).
    - out_data <= req_data_winner; out_src <= winner; out_valid <= 1; last_grant <= winner.
  - If can_load and req_valid == 0: req_ready = 0; out_valid <= 0. out_data and out_src hold their values; they are don't-care for the consumer.
  - If !can_load: req_ready = 0; all state holds.
- last_grant changes only on a grant.
- A requester that is not granted loses nothing. The block keeps no per-requester queue.
- Requester contract: hold req_valid and req_data_i stable until its req_ready bit is seen high. A requester may withdraw req_valid before a grant; the arbiter does not flag this.
- Reset (synchronous, wins over everything, including a reset asserted mid-transfer):
  - out_valid=0, out_data=0, out_src=0, last_grant=7, so requester 0 has first priority.
  - req_ready is forced to 0 while reset is high.
  - A word held in the output register at reset is discarded.

## Timing
- Latency: a word accepted in cycle N (req_ready bit high) appears on out_data with out_valid=1 in cycle N+1.
- Throughput: one word per cycle while out_ready stays high. A drain and a new load in the same cycle are allowed, so there are no bubbles.
- req_ready depends combinationally on req_valid, out_valid, out_ready and last_grant. It has no combinational path from req_data.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_src hold stable, and req_ready=0.
- Fairness: with all eight requesters continuously valid and no backpressure, each requester is granted exactly once in every 8 consecutive grants.
- Wrap-around: the search after a grant to 7 begins at 0, using mod-8 arithmetic on a 3-bit value.

## Test plan
- Reset:
  - Stimulus: hold reset high for 2 cycles with req_valid=0xFF and out_ready=1.
  - Response: req_ready=0x00, out_valid=0, out_data=0, out_src=0.
  - Then release reset with req_valid=0xFF. Response: req_ready=0x01 in the first cycle after release.
- Single requester:
  - Stimulus: req_valid=0x08, req_data_3=0xDEADBEEF, out_ready=1.
  - Response: req_ready=0x08 in the same cycle; next cycle out_valid=1, out_data=0xDEADBEEF, out_src=3.
- Full rotation:
  - Stimulus: req_valid=0xFF held, out_ready=1, req_data_i=0x1000_0000+i.
  - Response: out_src sequence 0,1,2,…,7,0 on consecutive cycles; out_data matches the source every cycle.
- Backpressure:
  - Stimulus: out_valid=1 with out_src=2, out_ready=0 for 3 cycles, req_valid=0xFF.
  - Response: req_ready=0 and out_data/out_src unchanged for those 3 cycles.
  - Then raise out_ready. Response: req_ready=0x08 in that same cycle, and out_src=3 in the next cycle.
- Wrap and skip:
  - Stimulus: last_grant=6, req_valid=0x41.
  - Response: first grant is requester 0 (7 is absent), the next grant is requester 6, then requester 0 again.
- Reset mid-operation:
  - Stimulus: out_valid=1, out_ready=0, then pulse reset for 1 cycle with req_valid=0x80.
  - Response: after reset, out_valid=0, out_data=0, out_src=0. The next cycle grants requester 7 (req_ready=0x80), and out_src=7 one cycle later.
